// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding select and load-use stall unit beside the EX stage.
// A shift-register scoreboard remembers the last DEPTH instructions that left
// EX (destination, write-enable, result-ready countdown). Each EX source operand
// is steered to its youngest in-flight producer, and EX is held while that
// producer's result is still being produced.
module fwd_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  input  logic [NUM_SRC-1:0]        ex_src_used_i,
  input  logic                      flush_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  // A countdown that only ever holds 0 still needs one bit of storage.
  localparam int RDY_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  typedef struct packed {
    logic              v;    // slot holds a real instruction
    logic              wr;   // instruction writes a register
    logic [REG_AW-1:0] rd;   // destination register
    logic [RDY_W-1:0]  rdy;  // cycles until the result can be forwarded
  } slot_t;

  // Slot 1 is EX/MEM, slot 2 is MEM/WB, and so on; lower index = younger.
  slot_t slots [1:DEPTH];

  logic [NUM_SRC-1:0] hazard;
  logic               issue;

  // Per-operand producer search: youngest matching slot wins, and its
  // readiness alone decides whether this operand causes a stall.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop leaves it unassigned and infers a latch.
    fwd_sel_o = '0;
    hazard    = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      // Walk oldest to youngest so the youngest match is written last.
      for (int k = DEPTH; k >= 1; k--) begin
        if (slots[k].v && slots[k].wr && (slots[k].rd != '0) &&
            (slots[k].rd == ex_src_i[n*REG_AW +: REG_AW]) &&
            ex_src_used_i[n] && ex_valid_i) begin
          fwd_sel_o[n*SEL_W +: SEL_W] = SEL_W'(k);
          hazard[n]                   = (slots[k].rdy != '0);
        end
      end
    end
  end

  // A flush kills the EX instruction, so it can never be waiting on anything.
  assign stall_o = (|hazard) && !flush_i;

  // The EX instruction moves into slot 1 only when it is real, not killed and
  // not held; every other cycle slot 1 receives a bubble.
  assign issue = ex_valid_i && !flush_i && !stall_o;

  // Scoreboard shift: slot 1 takes EX (or a bubble), older slots age by one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so every slot is
      // cleared; a stale valid bit after reset would create a phantom hazard.
      for (int k = 1; k <= DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's
      // pre-edge value, which is exactly the shift-register behaviour.
      if (issue) begin
        slots[1].v   <= 1'b1;
        slots[1].wr  <= ex_regwrite_i;
        slots[1].rd  <= ex_rd_i;
        slots[1].rdy <= ex_is_load_i ? RDY_W'(LOAD_LAT) : '0;
      end else begin
        slots[1] <= '0;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        slots[k].v   <= slots[k-1].v;
        slots[k].wr  <= slots[k-1].wr;
        slots[k].rd  <= slots[k-1].rd;
        slots[k].rdy <= (slots[k-1].rdy != '0) ? slots[k-1].rdy - 1'b1 : '0;
      end
    end
  end

  // Saturating count of cycles in which EX was held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: one instance with the default latency
// (LOAD_LAT=1) and one with LOAD_LAT=2 and a 3-bit stall counter.
module tb_fwd_scoreboard;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       is_load;
    logic [4:0] rd;
    logic [9:0] src;
    logic [1:0] used;
    logic       flush;
  } ex_t;

  logic clk;
  logic rst;
  ex_t  ex_a;
  ex_t  ex_b;

  logic [3:0]  sel_a;
  logic        stall_a;
  logic [15:0] cnt_a;
  logic [3:0]  sel_b;
  logic        stall_b;
  logic [2:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard u_dut_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_valid_i    (ex_a.valid),
    .ex_regwrite_i (ex_a.regwrite),
    .ex_is_load_i  (ex_a.is_load),
    .ex_rd_i       (ex_a.rd),
    .ex_src_i      (ex_a.src),
    .ex_src_used_i (ex_a.used),
    .flush_i       (ex_a.flush),
    .fwd_sel_o     (sel_a),
    .stall_o       (stall_a),
    .stall_cnt_o   (cnt_a)
  );

  fwd_scoreboard #(
    .LOAD_LAT (2),
    .CNT_W    (3)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_valid_i    (ex_b.valid),
    .ex_regwrite_i (ex_b.regwrite),
    .ex_is_load_i  (ex_b.is_load),
    .ex_rd_i       (ex_b.rd),
    .ex_src_i      (ex_b.src),
    .ex_src_used_i (ex_b.used),
    .flush_i       (ex_b.flush),
    .fwd_sel_o     (sel_b),
    .stall_o       (stall_b),
    .stall_cnt_o   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(input logic v, input logic rw, input logic ld,
                             input logic [4:0] rd, input logic [4:0] s0,
                             input logic [4:0] s1, input logic [1:0] used,
                             input logic fl);
    mk.valid    = v;
    mk.regwrite = rw;
    mk.is_load  = ld;
    mk.rd       = rd;
    mk.src      = {s1, s0};
    mk.used     = used;
    mk.flush    = fl;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam ex_t IDLE = '0;

  initial begin
    logic [31:0] r;
    rst  = 1'b1;
    ex_a = IDLE;
    ex_b = IDLE;
    tick();

    // Reset held with random EX inputs: outputs stay quiet.
    for (int i = 0; i < 2; i++) begin
      r = $urandom; ex_a = r[$bits(ex_t)-1:0];
      r = $urandom; ex_b = r[$bits(ex_t)-1:0];
      #1;
      check("rst_sel_a",   32'(sel_a),   32'h0);
      check("rst_stall_a", 32'(stall_a), 32'h0);
      check("rst_cnt_a",   32'(cnt_a),   32'h0);
      check("rst_sel_b",   32'(sel_b),   32'h0);
      check("rst_stall_b", 32'(stall_b), 32'h0);
      check("rst_cnt_b",   32'(cnt_b),   32'h0);
      tick();
    end
    rst  = 1'b0;
    ex_a = IDLE;
    ex_b = IDLE;
    #1;
    check("post_rst_stall_a", 32'(stall_a), 32'h0);

    // Priority: two ALU writers of r3, then a reader of r3 on both operands.
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0);
    #1;
    check("prio_first_sel", 32'(sel_a), 32'h0);
    tick();
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 2'b11, 1'b0);
    #1;
    check("prio_sel",   32'(sel_a),   32'h5);
    check("prio_stall", 32'(stall_a), 32'h0);
    tick();

    // Same pattern with r0: never forwarded.
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);
    #1;
    check("r0_sel",   32'(sel_a),   32'h0);
    check("r0_stall", 32'(stall_a), 32'h0);
    tick();

    // Load-use with LOAD_LAT=1: one stall cycle, then forward from slot 2.
    ex_a = mk(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 2'b01, 1'b0);
    #1;
    check("lu1_stall_sel", 32'(sel_a),   32'h1);
    check("lu1_stall",     32'(stall_a), 32'h1);
    check("lu1_cnt0",      32'(cnt_a),   32'h0);
    tick();
    check("lu1_fwd_sel",   32'(sel_a),   32'h2);
    check("lu1_fwd_stall", 32'(stall_a), 32'h0);
    check("lu1_cnt1",      32'(cnt_a),   32'h1);
    tick();

    // Younger unready load shadows an older ready ALU result (operand 1).
    ex_a = mk(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b10, 1'b0);
    #1;
    check("young_sel",   32'(sel_a),   32'h4);
    check("young_stall", 32'(stall_a), 32'h1);
    tick();
    check("young_fwd_sel",   32'(sel_a),   32'h8);
    check("young_fwd_stall", 32'(stall_a), 32'h0);
    check("young_cnt",       32'(cnt_a),   32'h2);
    tick();

    // Flushed load never enters the scoreboard.
    ex_a = mk(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 2'b00, 1'b1);
    #1;
    check("flush_ld_stall", 32'(stall_a), 32'h0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01, 1'b0);
    #1;
    check("flush_dep_sel",   32'(sel_a),   32'h0);
    check("flush_dep_stall", 32'(stall_a), 32'h0);
    tick();

    // Flush together with a hazard: flush wins.
    ex_a = mk(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 2'b01, 1'b1);
    #1;
    check("flush_hz_sel",   32'(sel_a),   32'h1);
    check("flush_hz_stall", 32'(stall_a), 32'h0);
    tick();
    ex_a = IDLE;
    #1;
    check("flush_hz_cnt", 32'(cnt_a), 32'h2);

    // Unused operand and invalid EX never select a producer.
    ex_a = mk(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_a = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0);
    #1;
    check("unused_sel",   32'(sel_a),   32'h0);
    check("unused_stall", 32'(stall_a), 32'h0);
    tick();
    ex_a = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9, 2'b11, 1'b0);
    #1;
    check("invalid_sel", 32'(sel_a), 32'h0);
    tick();
    ex_a = IDLE;

    // LOAD_LAT=2: two stall cycles, then forward from slot 3.
    ex_b = mk(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_b = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b0);
    #1;
    check("lu2_c1_sel",   32'(sel_b),   32'h1);
    check("lu2_c1_stall", 32'(stall_b), 32'h1);
    check("lu2_c1_cnt",   32'(cnt_b),   32'h0);
    tick();
    check("lu2_c2_sel",   32'(sel_b),   32'h2);
    check("lu2_c2_stall", 32'(stall_b), 32'h1);
    check("lu2_c2_cnt",   32'(cnt_b),   32'h1);
    tick();
    check("lu2_fwd_sel",   32'(sel_b),   32'h3);
    check("lu2_fwd_stall", 32'(stall_b), 32'h0);
    check("lu2_cnt",       32'(cnt_b),   32'h2);
    tick();

    // Four more load-use pairs: ten stall cycles in total saturate at 7.
    for (int p = 0; p < 4; p++) begin
      ex_b = mk(1'b1, 1'b1, 1'b1, 5'(12 + p), 5'd0, 5'd0, 2'b00, 1'b0);
      tick();
      ex_b = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'(12 + p), 5'd0, 2'b01, 1'b0);
      #1;
      check("sat_stall1", 32'(stall_b), 32'h1);
      tick();
      check("sat_stall2", 32'(stall_b), 32'h1);
      tick();
      check("sat_sel", 32'(sel_b),   32'h3);
      check("sat_go",  32'(stall_b), 32'h0);
      check("sat_cnt", 32'(cnt_b),   (p >= 2) ? 32'h7 : 32'(4 + 2 * p));
      tick();
    end

    // Reset in the middle of a stall drops it and discards the load.
    ex_b = mk(1'b1, 1'b1, 1'b1, 5'd20, 5'd0, 5'd0, 2'b00, 1'b0);
    tick();
    ex_b = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd20, 5'd0, 2'b01, 1'b0);
    #1;
    check("rstmid_pre_stall", 32'(stall_b), 32'h1);
    rst = 1'b1;
    tick();
    check("rstmid_stall", 32'(stall_b), 32'h0);
    check("rstmid_cnt",   32'(cnt_b),   32'h0);
    rst = 1'b0;
    tick();
    check("rstmid_after_stall", 32'(stall_b), 32'h0);
    check("rstmid_after_sel",   32'(sel_b),   32'h0);
    check("rstmid_after_cnt",   32'(cnt_b),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
